// File: rtl/ff_readback_if.sv
// Readback bus between the snapshot serializer and its consumer.
// master = ff_readback, slave = downstream consumer / storage bank driver.
interface ff_readback_if #(
    parameter int unsigned N_FF   = 64,
    parameter int unsigned WORD_W = 8
);
    logic              start;
    logic [N_FF-1:0]   q_in;
    logic              out_ready;
    logic              capture_en;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, q_in, out_ready,
        output capture_en, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output start, q_in, out_ready,
        input  capture_en, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/ff_readback.sv
// Freezes a storage-element bank, snapshots its Q bits and streams them out as words.
// Optional FF_READBACK_CRC_EN appends a CRC-8 (poly 0x07) word; that mode needs WORD_W = 8.
module ff_readback #(
    parameter int unsigned N_FF   = 64,
    parameter int unsigned WORD_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    ff_readback_if.master bus
);
    localparam int unsigned NW    = (N_FF + WORD_W - 1) / WORD_W;
    localparam int unsigned PAD_W = NW * WORD_W;
`ifdef FF_READBACK_CRC_EN
    localparam int unsigned NTOT  = NW + 1;
`else
    localparam int unsigned NTOT  = NW;
`endif
    localparam int unsigned IDX_W = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, SEND, DONE} state_t;

    state_t            state;
    logic [N_FF-1:0]   snapshot;
    logic [IDX_W-1:0]  idx;

    logic [PAD_W-1:0]  padded_c;
    logic [IDX_W-1:0]  sel_c;
    logic [WORD_W-1:0] word_c;
    logic              last_c;

`ifdef FF_READBACK_CRC_EN
    logic [7:0] crc;
    logic [7:0] crc_next_c;

    // CRC-8, MSB first, one byte per call
    function automatic logic [7:0] crc8(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction
`endif

    // Word to present next: word 0 on the first load, else the one after idx
    always_comb begin
        padded_c = PAD_W'(snapshot);
        sel_c    = bus.out_valid ? idx + IDX_W'(1) : '0;
        word_c   = WORD_W'(padded_c >> (32'(sel_c) * WORD_W));
`ifdef FF_READBACK_CRC_EN
        crc_next_c = crc8(crc, bus.out_data[7:0]);
        if (sel_c == IDX_W'(NW))
            word_c = WORD_W'(crc_next_c);
`endif
        last_c   = (sel_c == IDX_W'(NTOT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            snapshot       <= '0;
            idx            <= '0;
            bus.capture_en <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_last   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
`ifdef FF_READBACK_CRC_EN
            crc            <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state          <= CAPTURE;
                        bus.capture_en <= 1'b1;
                        bus.busy       <= 1'b1;
                    end
                end
                CAPTURE: begin
                    snapshot       <= bus.q_in;
                    idx            <= '0;
                    bus.capture_en <= 1'b0;
                    state          <= SEND;
`ifdef FF_READBACK_CRC_EN
                    crc            <= '0;
`endif
                end
                SEND: begin
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= word_c;
                        bus.out_last  <= last_c;
                    end else if (bus.out_ready) begin
                        if (bus.out_last) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.out_data  <= '0;
                            bus.done      <= 1'b1;
                        end else begin
                            idx          <= sel_c;
                            bus.out_data <= word_c;
                            bus.out_last <= last_c;
`ifdef FF_READBACK_CRC_EN
                            crc          <= crc_next_c;
`endif
                        end
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ff_readback.md
FF_READBACK -- requirements
Module: ff_readback

Interface
REQ-001 Parameter N_FF, default 64: number of storage-element Q bits captured per frame; N_FF >= 1.
REQ-002 Parameter WORD_W, default 8: output word width; WORD_W >= 1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request one readback frame; sampled only in IDLE.
REQ-006 q_in  input  N_FF  parallel Q outputs of the storage-element bank.
REQ-007 out_ready  input  1  downstream accepts the current word.
REQ-008 capture_en  output  1  one-cycle pulse, high during CAPTURE, freezing the bank's clock enables.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_data  output  WORD_W  serialized snapshot word.
REQ-011 out_last  output  1  current word is the final word of the frame.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-014 States SHALL be IDLE, CAPTURE, SEND and DONE, with no others.
REQ-015 IDLE -> CAPTURE when start=1; start SHALL be ignored in every other state.
REQ-016 CAPTURE SHALL last exactly one cycle, register q_in into an N_FF-bit snapshot, and then go to SEND with the word index at 0.
REQ-017 The first out_valid SHALL be high 2 cycles after the edge that samples start.
REQ-018 NW = ceil(N_FF/WORD_W) data words; word k = snapshot[k*WORD_W +: WORD_W]; bits beyond N_FF-1 in the last word read as 0.
REQ-019 A handshake occurs on a rising edge with out_valid=1 and out_ready=1; the index advances only on a handshake.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_last SHALL be held unchanged.
REQ-021 out_valid SHALL stay high between words; back-to-back handshakes give one word per cycle.
REQ-022 out_last=1 only on the final word of the frame.
REQ-023 A handshake on the final word moves to DONE; DONE asserts done for 1 cycle and returns to IDLE; out_valid=0 in DONE.
REQ-024 q_in changes after CAPTURE SHALL NOT affect the frame.
REQ-025 The index counter SHALL be ceil(log2(NW+1)) bits wide and never wrap within a frame.
REQ-026 N_FF <= WORD_W yields a single word with out_last=1.

Reset
REQ-027 rst_n=0 forces IDLE and drives out_valid, out_last, busy, done, capture_en and out_data to 0, and clears the snapshot and index, regardless of clk.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no done pulse; the first frame after reset release requires a new start.

Configuration
REQ-029 Macro FF_READBACK_CRC_EN, when defined, appends one CRC word after the NW data words.
REQ-030 CRC: CRC-8, poly 0x07, init 0x00, MSB first, no reflection, no final XOR, over the data words as transmitted (padding included); requires WORD_W = 8.
REQ-031 With the macro, out_last moves to the CRC word and the frame is NW+1 words; without it, the frame is NW words and no CRC logic is present.

Verification
REQ-032 N_FF=20, WORD_W=8, q_in=20'hABCDE, out_ready=1, start pulse -> out_data 0xDE, 0xBC, 0x0A on consecutive cycles, out_last on 0x0A, done 1 cycle later.
REQ-033 Same frame with out_ready=0 for 3 cycles on word 1 -> 0xBC held stable with out_valid=1 for 4 cycles, no word lost or duplicated.
REQ-034 q_in changed to 20'h12345 in the cycle after CAPTURE -> frame still 0xDE, 0xBC, 0x0A.
REQ-035 start held high through the whole frame -> exactly one frame, then a new frame begins from IDLE.
REQ-036 rst_n pulsed low while word 1 is valid -> all outputs 0 asynchronously, no done, IDLE after release.
REQ-037 FF_READBACK_CRC_EN defined, N_FF=8, q_in=8'h01 -> words 0x01 then 0x07, out_last on 0x07.
